// File: rtl/memory_ctrl_sized.sv
// Byte-addressed, big-endian 64-bit memory controller with 8/16/32/64-bit accesses.
// Accesses that straddle a word boundary take a second cycle on the single RAM port.
module memory_ctrl_sized #(
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter bit          INIT_ON_RESET = 1'b1,
    parameter logic [63:0] INIT_VALUE    = 64'h0
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [1:0]            i_size,
    input  logic [ADDR_WIDTH-1:0] i_addr_hi,
    input  logic [2:0]            i_addr_lo,
    input  logic [63:0]           i_write_data,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic [63:0]           o_data,
    output logic                  o_error
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {StInit, StIdle, StRead2, StWrite2} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] init_cnt_q;
    logic [ADDR_WIDTH-1:0] addr2_q;
    logic [2:0]            lo_q;
    logic [1:0]            size_q;
    logic [63:0]           wdata_q;
    logic [63:0]           word0_q;
    logic                  valid_q;
    logic                  error_q;
    logic [63:0]           data_q;

    logic [63:0] mem [DEPTH];

    logic                  in_idle;
    logic [2:0]            cur_lo;
    logic [1:0]            cur_size;
    logic [63:0]           cur_wdata;
    logic [3:0]            nbytes;
    logic [4:0]            shift;
    logic [63:0]           size_mask;
    logic [15:0]           be_win;
    logic [127:0]          wwin;
    logic [127:0]          rwin;
    logic [63:0]           rext;
    logic                  spanning;
    logic                  req_any;
    logic                  req_both;
    logic                  bound_err;
    logic                  accept_wr;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [63:0]           ram_rdata;
    logic [63:0]           ram_wdata;
    logic [7:0]            ram_be;

    // The access is placed in a 16-byte window {word addr_hi, word addr_hi+1}; shift is the
    // number of bytes between the access's last byte and the window's LSB.
    always_comb begin
        in_idle   = (state_q == StIdle);
        cur_lo    = in_idle ? i_addr_lo : lo_q;
        cur_size  = in_idle ? i_size : size_q;
        cur_wdata = in_idle ? i_write_data : wdata_q;
        nbytes    = 4'd1 << cur_size;
        shift     = 5'd16 - 5'(cur_lo) - 5'(nbytes);
        size_mask = ~64'd0 >> {(4'd8 - nbytes), 3'b000};
        be_win    = 16'(((32'd1 << nbytes) - 32'd1) << shift);
        wwin      = {64'd0, cur_wdata & size_mask} << {shift, 3'b000};
        spanning  = ({1'b0, cur_lo} + nbytes) > 4'd8;

        req_any   = i_read | i_write;
        req_both  = i_read & i_write;
        bound_err = spanning && (i_addr_hi == '1);
        accept_wr = in_idle && i_write && !i_read && !bound_err;

        case (state_q)
            StInit:  ram_addr = init_cnt_q;
            StIdle:  ram_addr = i_addr_hi;
            default: ram_addr = addr2_q;
        endcase
        ram_rdata = mem[ram_addr];

        rwin = in_idle ? {ram_rdata, 64'd0} : {word0_q, ram_rdata};
        rext = 64'(rwin >> {shift, 3'b000}) & size_mask;

        ram_be    = '0;
        ram_wdata = '0;
        if (!i_areset) begin
            case (state_q)
                StInit: begin
                    ram_be    = 8'hFF;
                    ram_wdata = INIT_VALUE;
                end
                StIdle: begin
                    if (accept_wr) begin
                        ram_be    = be_win[15:8];
                        ram_wdata = wwin[127:64];
                    end
                end
                StWrite2: begin
                    ram_be    = be_win[7:0];
                    ram_wdata = wwin[63:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 8; b++) begin
            if (ram_be[b]) begin
                mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            state_q    <= INIT_ON_RESET ? StInit : StIdle;
            init_cnt_q <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
            unique case (state_q)
                StInit: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    error_q    <= req_any;
                    if (init_cnt_q == '1) begin
                        state_q <= StIdle;
                    end
                end
                StIdle: begin
                    if (req_both || (req_any && bound_err)) begin
                        error_q <= 1'b1;
                    end else if (req_any) begin
                        if (spanning) begin
                            addr2_q <= i_addr_hi + 1'b1;
                            lo_q    <= i_addr_lo;
                            size_q  <= i_size;
                            wdata_q <= i_write_data;
                            word0_q <= ram_rdata;
                            state_q <= i_read ? StRead2 : StWrite2;
                        end else if (i_read) begin
                            valid_q <= 1'b1;
                            data_q  <= rext;
                        end
                    end
                end
                StRead2: begin
                    valid_q <= 1'b1;
                    data_q  <= rext;
                    error_q <= req_any;
                    state_q <= StIdle;
                end
                StWrite2: begin
                    error_q <= req_any;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_busy  = (state_q != StIdle);
    assign o_valid = valid_q;
    assign o_error = error_q;
    assign o_data  = data_q;

endmodule

// File: tb/tb_memory_ctrl_sized.sv
// Scoreboard bench for memory_ctrl_sized: a byte-array model predicts every response and
// its cycle; a monitor compares the DUT outputs against the predictions each cycle.
module tb_memory_ctrl_sized;

    localparam logic [63:0] INIT_V = 64'hF0F1F2F3F4F5F6F7;

    logic        clk = 1'b0;
    logic        areset;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic [7:0]  addr_hi;
    logic [2:0]  addr_lo;
    logic [63:0] wdata;
    logic        busy;
    logic        valid;
    logic [63:0] data;
    logic        error;

    memory_ctrl_sized #(
        .ADDR_WIDTH   (8),
        .INIT_ON_RESET(1'b1),
        .INIT_VALUE   (INIT_V)
    ) dut (
        .i_clk       (clk),
        .i_areset    (areset),
        .i_read      (rd),
        .i_write     (wr),
        .i_size      (size),
        .i_addr_hi   (addr_hi),
        .i_addr_lo   (addr_lo),
        .i_write_data(wdata),
        .o_busy      (busy),
        .o_valid     (valid),
        .o_data      (data),
        .o_error     (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mem_m[2048];
    logic [63:0] last_data;
    int          busy_at;
    int          errors;
    int          checks;

    task automatic chk_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push_exp(input bit is_err, input logic [63:0] d, input int c);
        exp_t e;
        e.is_err = is_err;
        e.data   = d;
        e.cyc    = c;
        exp_q.push_back(e);
    endtask

    // One comparison per cycle: valid/error/data must match what the model scheduled for it.
    task automatic mon_step();
        exp_t        e;
        logic        ev;
        logic        ee;
        logic [63:0] ed;
        if (areset) begin
            last_data = '0;
            return;
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_response: got nothing, expected err=%0b data=%h at cycle %0d",
                     e.is_err, e.data, e.cyc);
        end
        ev = 1'b0;
        ee = 1'b0;
        ed = last_data;
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            if (e.is_err) begin
                ee = 1'b1;
            end else begin
                ev = 1'b1;
                ed = e.data;
            end
        end
        checks++;
        if (valid !== ev || error !== ee || data !== ed) begin
            errors++;
            $display("FAIL response@%0d: got valid=%b error=%b data=%h, expected valid=%b error=%b data=%h",
                     cyc, valid, error, data, ev, ee, ed);
        end
        last_data = ed;
    endtask

    // Issue one request in the current cycle and record what the model says must follow.
    task automatic issue(input bit r, input bit w, input logic [1:0] sz, input logic [7:0] hi,
                         input logic [2:0] lo, input logic [63:0] wd);
        int          n;
        int          addr;
        bit          span;
        bit          busy_m;
        logic [63:0] res;
        busy_m = (cyc == busy_at);
        chk_int("busy", int'(busy), int'(busy_m));
        n    = 1 << sz;
        span = (lo + n) > 8;
        addr = hi * 8 + lo;
        if ((r || w) && (busy_m || (r && w) || (span && hi == 8'd255))) begin
            push_exp(1'b1, '0, cyc + 1);
        end else if (r) begin
            res = '0;
            for (int i = 0; i < n; i++) res = {res[55:0], mem_m[addr + i]};
            push_exp(1'b0, res, cyc + (span ? 2 : 1));
            if (span) busy_at = cyc + 1;
        end else if (w) begin
            for (int i = 0; i < n; i++) mem_m[addr + i] = wd[8*(n-1-i) +: 8];
            if (span) busy_at = cyc + 1;
        end
        rd      = r;
        wr      = w;
        size    = sz;
        addr_hi = hi;
        addr_lo = lo;
        wdata   = wd;
        @(posedge clk);
        #1;
        rd      = 1'b0;
        wr      = 1'b0;
        size    = 2'($urandom);
        addr_hi = 8'($urandom);
        addr_lo = 3'($urandom);
        wdata   = {$urandom(), $urandom()};
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) issue(1'b0, 1'b0, 2'd0, 8'd0, 3'd0, 64'd0);
    endtask

    task automatic do_reset();
        int          n;
        logic [63:0] iv;
        areset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_int("reset_valid", int'(valid), 0);
        chk_int("reset_error", int'(error), 0);
        chk64("reset_data", data, 64'd0);
        areset = 1'b0;
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        chk_int("init_busy_cycles", n, 256);
        @(posedge clk);
        #1;
        iv = INIT_V;
        for (int i = 0; i < 2048; i++) mem_m[i] = iv[8*(7-(i%8)) +: 8];
        busy_at = -1;
    endtask

    initial begin
        int          op;
        logic [7:0]  hi;
        errors  = 0;
        checks  = 0;
        busy_at = -1;
        last_data = '0;
        areset  = 1'b1;
        rd      = 1'b0;
        wr      = 1'b0;
        size    = '0;
        addr_hi = '0;
        addr_lo = '0;
        wdata   = '0;
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        do_reset();
        issue(1, 0, 2'd3, 8'd0, 3'd0, 64'd0);
        issue(1, 0, 2'd3, 8'd255, 3'd0, 64'd0);

        issue(0, 1, 2'd3, 8'd5, 3'd0, 64'h0011223344556677);
        issue(1, 0, 2'd3, 8'd5, 3'd0, 64'd0);
        issue(0, 1, 2'd1, 8'd5, 3'd2, 64'hFFFFFFFFFFFFABCD);
        issue(1, 0, 2'd3, 8'd5, 3'd0, 64'd0);
        issue(1, 0, 2'd0, 8'd5, 3'd3, 64'd0);

        issue(0, 1, 2'd3, 8'd15, 3'd6, 64'h0204006830A8DCE1);
        idle(1);
        issue(1, 0, 2'd3, 8'd15, 3'd6, 64'd0);
        idle(1);
        issue(1, 0, 2'd3, 8'd15, 3'd0, 64'd0);
        issue(1, 0, 2'd3, 8'd16, 3'd0, 64'd0);

        issue(1, 0, 2'd3, 8'd255, 3'd4, 64'd0);
        issue(1, 1, 2'd2, 8'd3, 3'd0, 64'h1234);
        issue(1, 0, 2'd2, 8'd15, 3'd6, 64'd0);
        issue(0, 1, 2'd3, 8'd15, 3'd0, 64'hDEADBEEFDEADBEEF);
        issue(1, 0, 2'd3, 8'd15, 3'd0, 64'd0);
        issue(0, 1, 2'd3, 8'd255, 3'd1, 64'h1111111111111111);
        issue(1, 0, 2'd3, 8'd255, 3'd0, 64'd0);
        idle(3);

        issue(0, 1, 2'd3, 8'd15, 3'd6, 64'hA5A5A5A5A5A5A5A5);
        do_reset();
        issue(1, 0, 2'd3, 8'd15, 3'd0, 64'd0);
        issue(1, 0, 2'd3, 8'd16, 3'd0, 64'd0);

        for (int t = 0; t < 400; t++) begin
            op = $urandom_range(0, 9);
            hi = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7))
                                             : 8'($urandom_range(248, 255));
            issue(op == 0 || (op >= 1 && op <= 4), op == 0 || (op >= 5 && op <= 8),
                  2'($urandom), hi, 3'($urandom), {$urandom(), $urandom()});
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        idle(4);
        while (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            checks++;
            errors++;
            $display("FAIL leftover_response: got nothing, expected a pending response");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_ctrl_sized.md
MEMORY_CTRL_SIZED -- requirements
Module: memory_ctrl_sized

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, word-address width; DEPTH = 2**ADDR_WIDTH 64-bit words.
REQ-002 SHALL have parameter INIT_ON_RESET, default 1, fill RAM after reset when 1.
REQ-003 SHALL have parameter INIT_VALUE, default 64'h0, fill word.
REQ-004 SHALL have port i_clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port i_areset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_read  input  1  read request.
REQ-007 SHALL have port i_write  input  1  write request.
REQ-008 SHALL have port i_size  input  2  access size: 0=8, 1=16, 2=32, 3=64 bits.
REQ-009 SHALL have port i_addr_hi  input  ADDR_WIDTH  word address.
REQ-010 SHALL have port i_addr_lo  input  3  byte offset in word.
REQ-011 SHALL have port i_write_data  input  64  write data, right-justified, unused MSBs ignored.
REQ-012 SHALL have port o_busy  output  1  requests not accepted.
REQ-013 SHALL have port o_valid  output  1  one-cycle pulse, o_data valid.
REQ-014 SHALL have port o_data  output  64  read data, right-justified, zero-extended.
REQ-015 SHALL have port o_error  output  1  one-cycle pulse, request rejected.

Function
REQ-016 SHALL use big-endian byte order: byte address {addr_hi,addr_lo}, offset 0 = word bits 63:56.
REQ-017 SHALL store data in one single-port RAM with 8 byte-lane write enables, one access per cycle.
REQ-018 SHALL accept a request only in cycle N with o_busy=0 and exactly one of i_read/i_write high.
REQ-019 SHALL classify an access as spanning when addr_lo + bytes(i_size) > 8.
REQ-020 SHALL complete a non-spanning read with o_valid=1 and o_data set in cycle N+1, o_busy staying 0.
REQ-021 SHALL complete a spanning read by reading word addr_hi in N and addr_hi+1 in N+1, o_busy=1 in N+1, o_valid in N+2.
REQ-022 SHALL commit a non-spanning write in one cycle, updating only the addressed byte lanes.
REQ-023 SHALL commit a spanning write as lanes of word addr_hi at end of N and word addr_hi+1 at end of N+1, o_busy=1 in N+1.
REQ-024 SHALL use FSM states INIT, IDLE, READ2, WRITE2: IDLE->READ2 on spanning read, IDLE->WRITE2 on spanning write, both returning to IDLE after one cycle.
REQ-025 SHALL latch address, size and write data on acceptance; input changes during busy SHALL NOT affect the access.
REQ-026 SHALL make written data visible to a read accepted the next cycle, including spanning writes.
REQ-027 SHALL reject a spanning access with addr_hi = DEPTH-1: o_error pulse in N+1, no RAM change, no o_valid.
REQ-028 SHALL reject i_read and i_write asserted together: o_error pulse in N+1, no action.
REQ-029 SHALL reject a request while o_busy=1: o_error pulse the next cycle, request dropped, current access unaffected.
REQ-030 SHALL hold o_data at its last value between o_valid pulses.

Reset
REQ-031 SHALL, while i_areset=1 at a clock edge, force o_valid=0, o_error=0, o_data=0.
REQ-032 SHALL, with INIT_ON_RESET=1, enter INIT after reset: write INIT_VALUE to words 0..DEPTH-1 one per cycle, o_busy=1 for DEPTH cycles, then IDLE.
REQ-033 SHALL, with INIT_ON_RESET=0, enter IDLE with o_busy=0 after reset; RAM contents undefined.
REQ-034 SHALL, on reset during READ2/WRITE2/INIT, abort the access and restart per REQ-032/033; a half-done spanning write is not completed.

Verification
REQ-035 Init: INIT_VALUE=64'hF0F1F2F3F4F5F6F7, release reset -> o_busy high 256 cycles, then 64-bit reads of words 0 and 255 return F0F1F2F3F4F5F6F7.
REQ-036 Aligned: write 64'h0011223344556677 to word 5, read size 3 addr 5:0 -> o_valid next cycle, o_data=0011223344556677.
REQ-037 Sub-word: after REQ-036, write size 1 data 16'hABCD at 5:2, read size 3 at 5:0 -> 0011ABCD44556677; read size 0 at 5:3 -> 64'h00000000000000CD.
REQ-038 Spanning: write size 3 64'h0204006830A8DCE1 at byte 0x7E -> o_busy 1 cycle; read size 3 at 0x7E -> o_valid 2 cycles later, 0204006830A8DCE1; words 15 and 16 keep untouched bytes.
REQ-039 Errors: spanning read at 255:4; read+write together; request during o_busy -> one o_error pulse each, RAM unchanged, no o_valid.
REQ-040 Reset mid-write: assert reset in WRITE2 cycle -> second word not written, init restarts, o_busy high DEPTH cycles.
